// File: rtl/uart_pkg.sv
// Shared UART constants: oversample rate, majority-vote tick positions,
// FSM state encodings and the baud divider calculation.
package uart_pkg;

   localparam int         OS_RATE = 16;
   localparam logic [3:0] SAMP_A  = 4'd7;
   localparam logic [3:0] SAMP_B  = 4'd8;
   localparam logic [3:0] SAMP_C  = 4'd9;
   localparam logic [3:0] S_LAST  = 4'd15;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   function automatic int calc_div(input int clock_freq, input int baud_rate);
      return clock_freq / (baud_rate * OS_RATE);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable 16x oversample tick generator; restart realigns the count
// to zero so sampling phase follows the detected start edge.
module uart_baud_gen #(
   parameter int DIV = 651
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (restart || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver: majority-vote sampling, optional parity,
// ready/valid holding register with frame/parity/overrun reporting.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DBIT       = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic            frame_err,
   output logic            parity_err,
   output logic            overrun_err,
   output logic            rx_done_tick
);

   localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);

   logic [1:0]      sync;
   logic            rxs;
   logic [2:0]      state;
   logic [3:0]      s;
   logic [3:0]      bit_idx;
   logic            stop_idx;
   logic            armed;
   logic [1:0]      samp;
   logic [DBIT-1:0] shreg;
   logic            fe_p, pe_p;
   logic            tick, start_det, maj, decide, bit_end, last_stop, commit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= 2'b11;
      else          sync <= {sync[0], rx};
   end
   assign rxs = sync[1];

   assign start_det = (state == ST_IDLE) && armed && !rxs;

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (start_det),
      .tick    (tick)
   );

   // Third vote is the live sample at tick 9, so the decision lands on that tick.
   assign maj       = (samp[1] & samp[0]) | (samp[1] & rxs) | (samp[0] & rxs);
   assign decide    = tick && (s == SAMP_C);
   assign bit_end   = tick && (s == S_LAST);
   assign last_stop = (STOP_BITS == 1) || stop_idx;
   assign commit    = (state == ST_STOP) && decide && last_stop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         s        <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         armed    <= 1'b0;
         samp     <= 2'b00;
         shreg    <= '0;
         fe_p     <= 1'b0;
         pe_p     <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (rxs) armed <= 1'b1;
         if (start_det) begin
            state <= ST_START;
            s     <= '0;
            fe_p  <= 1'b0;
            pe_p  <= 1'b0;
         end
      end else begin
         if (tick) begin
            s <= s + 1'b1;
            if (s == SAMP_A) samp[1] <= rxs;
            if (s == SAMP_B) samp[0] <= rxs;
         end
         case (state)
            ST_START: begin
               if (decide && maj)
                  state <= ST_IDLE;
               else if (bit_end) begin
                  state   <= ST_DATA;
                  bit_idx <= '0;
               end
            end
            ST_DATA: begin
               if (decide) shreg <= {maj, shreg[DBIT-1:1]};
               if (bit_end) begin
                  if (bit_idx == 4'(DBIT - 1)) begin
                     state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                     stop_idx <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (decide && (maj != (^shreg ^ 1'(PARITY_ODD)))) pe_p <= 1'b1;
               if (bit_end) begin
                  state    <= ST_STOP;
                  stop_idx <= 1'b0;
               end
            end
            ST_STOP: begin
               // A low stop bit disarms so a held-low break reports only once.
               if (decide) begin
                  if (!maj) begin
                     fe_p  <= 1'b1;
                     armed <= 1'b0;
                  end
                  if (last_stop) state <= ST_IDLE;
               end else if (bit_end) begin
                  stop_idx <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
         overrun_err  <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         overrun_err  <= 1'b0;
         if (commit) begin
            // Same-cycle accept frees the register, so the new frame loads.
            if (!rx_valid || rx_ready) begin
               rx_data      <= shreg;
               frame_err    <= fe_p | ~maj;
               parity_err   <= pe_p;
               rx_valid     <= 1'b1;
               rx_done_tick <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed plus randomized bench for uart_rx_os16: an 8N1 instance and an
// even-parity instance, checked against frames built from the line rules.
module tb_uart_rx_os16;

   localparam int CF      = 16000000;
   localparam int BR      = 1000000;
   localparam int BIT_CYC = 16;
   localparam int COMMIT_OFS = 156;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic rx = 1'b1, rx_ready = 1'b1;
   logic rxp = 1'b1, rxp_ready = 1'b1;

   logic [7:0] rx_data, p_data;
   logic rx_valid, frame_err, parity_err, overrun_err, rx_done_tick;
   logic p_valid, p_fe, p_pe, p_ovr, p_done;

   int n_assert = 0;
   int n_fail   = 0;
   int unsigned cyc = 0;
   int unsigned t_start = 0;
   int ovr_cnt = 0, ovrp_cnt = 0;

   logic [9:0] frm_q[$];
   logic [9:0] frmp_q[$];
   logic [7:0] acc_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_os16 #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
      .clk(clk), .reset_n(reset_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
      .overrun_err(overrun_err), .rx_done_tick(rx_done_tick));

   uart_rx_os16 #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .PARITY_EN(1), .PARITY_ODD(0)) dutp (
      .clk(clk), .reset_n(reset_n), .rx(rxp), .rx_data(p_data), .rx_valid(p_valid),
      .rx_ready(rxp_ready), .frame_err(p_fe), .parity_err(p_pe),
      .overrun_err(p_ovr), .rx_done_tick(p_done));

   // Frame capture away from the active edge; handshakes seen as the DUT sees them.
   always @(negedge clk) begin
      if (rx_done_tick) frm_q.push_back({parity_err, frame_err, rx_data});
      if (p_done)       frmp_q.push_back({p_pe, p_fe, p_data});
      if (overrun_err)  ovr_cnt  <= ovr_cnt + 1;
      if (p_ovr)        ovrp_cnt <= ovrp_cnt + 1;
   end
   always @(posedge clk) if (rx_valid && rx_ready) acc_q.push_back(rx_data);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_frame(input bit sel, input string tag, input logic [7:0] d,
                            input logic fe, input logic pe);
      logic [9:0] f;
      int n;
      n = sel ? frmp_q.size() : frm_q.size();
      chk({tag, ".frames"}, n, 1);
      if (n != 0) begin
         if (sel) f = frmp_q.pop_front();
         else     f = frm_q.pop_front();
         chk({tag, ".data"}, f[7:0], d);
         chk({tag, ".frame_err"}, f[8], fe);
         chk({tag, ".parity_err"}, f[9], pe);
      end
      frm_q.delete();
      frmp_q.delete();
   endtask

   task automatic set_line(input bit sel, input logic b);
      if (sel) rxp = b; else rx = b;
   endtask

   task automatic drive_bit(input bit sel, input logic b);
      @(negedge clk);
      set_line(sel, b);
      repeat (BIT_CYC - 1) @(negedge clk);
   endtask

   // Start bit, LSB-first data, optional parity, one stop bit, then idle-high gap.
   task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                       input logic par, input logic stop, input int gap);
      @(negedge clk);
      t_start = cyc;
      set_line(sel, 1'b0);
      repeat (BIT_CYC - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
      if (par_en) drive_bit(sel, par);
      drive_bit(sel, stop);
      if (gap > 0) begin
         @(negedge clk);
         set_line(sel, 1'b1);
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic stop, par;
      int ovr0;

      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.rx_valid", rx_valid, 0);
      chk("reset.rx_data", rx_data, 0);
      chk("reset.flags", {frame_err, parity_err, overrun_err, rx_done_tick}, 0);
      chk("reset.p_outputs", {p_valid, p_fe, p_pe, p_ovr, p_done, p_data}, 0);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);

      // Basic 8N1 byte with a ready consumer
      send(0, 8'hA5, 0, 0, 1, 20);
      chk_frame(0, "a5", 8'hA5, 0, 0);
      chk("a5.valid_one_cycle", rx_valid, 0);

      // Short low glitch is a false start
      @(negedge clk); rx = 1'b0;
      repeat (4) @(negedge clk); rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch.no_frame", frm_q.size(), 0);
      send(0, 8'h5A, 0, 0, 1, 20);
      chk_frame(0, "after_glitch", 8'h5A, 0, 0);

      // Bad stop bit rolling into a held-low break: one report only
      send(0, 8'h3C, 0, 0, 0, 0);
      repeat (3 * 10 * BIT_CYC) @(negedge clk);
      chk_frame(0, "break", 8'h3C, 1, 0);
      rx = 1'b1;
      repeat (2 * BIT_CYC) @(negedge clk);
      send(0, 8'h55, 0, 0, 1, 20);
      chk_frame(0, "after_break", 8'h55, 0, 0);

      // Even parity: 0x07 has three ones, so parity bit must be 1
      send(1, 8'h07, 1, 0, 1, 20);
      chk_frame(1, "par_bad", 8'h07, 0, 1);
      send(1, 8'h07, 1, 1, 1, 20);
      chk_frame(1, "par_good", 8'h07, 0, 0);

      // Overrun: stalled consumer keeps the first byte
      ovr0 = ovr_cnt;
      rx_ready = 1'b0;
      acc_q.delete();
      send(0, 8'h11, 0, 0, 1, 20);
      chk_frame(0, "ovr_first", 8'h11, 0, 0);
      send(0, 8'h22, 0, 0, 1, 20);
      chk("ovr.no_frame", frm_q.size(), 0);
      chk("ovr.pulses", ovr_cnt - ovr0, 1);
      chk("ovr.held_data", rx_data, 8'h11);
      chk("ovr.held_valid", rx_valid, 1);

      // Accept lands on the commit cycle of 0x33 (tick 9 of stop bit)
      ovr0 = ovr_cnt;
      t_start = 0;
      fork
         send(0, 8'h33, 0, 0, 1, 20);
         begin
            wait (t_start != 0);
            wait (cyc == t_start + COMMIT_OFS);
            @(negedge clk); rx_ready = 1'b1;
            @(negedge clk); rx_ready = 1'b0;
         end
      join
      chk_frame(0, "same_cycle", 8'h33, 0, 0);
      chk("same_cycle.no_overrun", ovr_cnt - ovr0, 0);
      chk("same_cycle.valid", rx_valid, 1);
      chk("same_cycle.data", rx_data, 8'h33);
      chk("same_cycle.accepted_cnt", acc_q.size(), 1);
      if (acc_q.size() != 0) chk("same_cycle.accepted", acc_q[0], 8'h11);
      rx_ready = 1'b1;
      repeat (4) @(negedge clk);

      // Reset in the middle of data bit 4 of 0xFF aborts the frame
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreset.valid", rx_valid, 0);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midreset.no_frame", frm_q.size(), 0);
      send(0, 8'h81, 0, 0, 1, 20);
      chk_frame(0, "after_reset", 8'h81, 0, 0);

      // Random bytes; roughly a quarter carry a bad stop bit
      for (int k = 0; k < 8; k++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send(0, d, 0, 0, stop, 20);
         chk_frame(0, $sformatf("rand8n1_%0d", k), d, ~stop, 0);
      end
      for (int k = 0; k < 6; k++) begin
         d   = 8'($urandom);
         par = 1'($urandom_range(0, 1));
         send(1, d, 1, par, 1, 20);
         chk_frame(1, $sformatf("randpar_%0d", k), d, 0, par != (^d));
      end
      chk("final.overruns", ovr_cnt, 1);
      chk("final.p_overruns", ovrp_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
